// File: rtl/alu_issue_ctrl_if.sv
// Instruction, host-preload, debug and ALU signals of the ALU issue controller.
// slave is the controller side; master is the fetch/host/ALU environment side.
interface alu_issue_ctrl_if #(
  parameter int unsigned OPERAND_W = 8,
  parameter int unsigned OPC_W     = 4
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [15:0]          instr_word;
  logic                 host_we;
  logic [3:0]           host_addr;
  logic [OPERAND_W-1:0] host_data;
  logic [3:0]           dbg_addr;
  logic [OPERAND_W-1:0] dbg_data;
  logic [OPC_W-1:0]     alu_instruction;
  logic [OPERAND_W-1:0] alu_operand_A;
  logic [OPERAND_W-1:0] alu_operand_B;
  logic [OPERAND_W-1:0] alu_operand_C;
  logic                 alu_ov;
  logic                 alu_un;
  logic                 alu_agt;
  logic                 alu_bgt;
  logic                 alu_eq;
  logic [4:0]           flags;
  logic                 done;
  logic                 err;

  modport slave (
    input  instr_valid, instr_word, host_we, host_addr, host_data, dbg_addr,
           alu_operand_C, alu_ov, alu_un, alu_agt, alu_bgt, alu_eq,
    output instr_ready, dbg_data, alu_instruction, alu_operand_A, alu_operand_B,
           flags, done, err
  );

  modport master (
    output instr_valid, instr_word, host_we, host_addr, host_data, dbg_addr,
           alu_operand_C, alu_ov, alu_un, alu_agt, alu_bgt, alu_eq,
    input  instr_ready, dbg_data, alu_instruction, alu_operand_A, alu_operand_B,
           flags, done, err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues decoded register-file instructions to an external ALU and writes results back.
// Three-state sequence per instruction: accept/read, ALU evaluate, capture/writeback.
module alu_issue_ctrl #(
  parameter int unsigned OPERAND_W = 8,
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned NREGS     = 16
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  localparam logic [OPC_W-1:0] OpNop = OPC_W'(0);
  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpSub = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpAnd = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpOr  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OpNot = OPC_W'(5);

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] regs_q [NREGS];
  logic [3:0]           rd_q, rd_d;
  logic [OPC_W-1:0]     alu_instr_q, alu_instr_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  logic [4:0]           flags_q, flags_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 known_op;
  logic                 wb_en;
  logic                 host_en;
  logic [3:0]           ra, rb;

  assign ra              = bus.instr_word[7:4];
  assign rb              = bus.instr_word[3:0];
  assign bus.instr_ready = (state_q == StIdle);
  assign accept          = bus.instr_valid & (state_q == StIdle);
  // Preload only when no instruction could be accepted on the same edge.
  assign host_en         = (state_q == StIdle) & ~bus.instr_valid & bus.host_we;
  assign known_op        = alu_instr_q inside {OpAdd, OpSub, OpAnd, OpOr, OpNot};

  assign bus.dbg_data        = regs_q[bus.dbg_addr];
  assign bus.alu_instruction = alu_instr_q;
  assign bus.alu_operand_A   = op_a_q;
  assign bus.alu_operand_B   = op_b_q;
  assign bus.flags           = flags_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    alu_instr_d = alu_instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wb_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StIssue;
          rd_d        = bus.instr_word[11:8];
          alu_instr_d = OPC_W'(bus.instr_word[15:12]);
          op_a_d      = regs_q[ra];
          op_b_d      = regs_q[rb];
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d     = StIdle;
        done_d      = 1'b1;
        alu_instr_d = OpNop;
        if (known_op) begin
          wb_en   = 1'b1;
          flags_d = {bus.alu_ov, bus.alu_un, bus.alu_agt, bus.alu_bgt, bus.alu_eq};
        end else if (alu_instr_q != OpNop) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      alu_instr_q <= OpNop;
      op_a_q      <= '0;
      op_b_q      <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      alu_instr_q <= alu_instr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Writeback and host preload are exclusive by state, so one write port suffices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[rd_q] <= bus.alu_operand_C;
    end else if (host_en) begin
      regs_q[bus.host_addr] <= bus.host_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU on the negedge plus an
// instruction-level reference model of the register file and flags.
module tb_alu_issue_ctrl;
  localparam int W  = 8;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.OPERAND_W(W), .OPC_W(OW)) bus ();

  alu_issue_ctrl #(.OPERAND_W(W), .OPC_W(OW), .NREGS(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] ref_regs [16];
  logic [4:0]   ref_flags;

  // Signed ALU: returns {C, ov, un, agt, bgt, eq}; unknown/NOP opcodes give junk.
  function automatic logic [W+4:0] alu_eval(input logic [3:0] opc, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int sa, sb, s;
    logic [W-1:0] c;
    logic ov, un;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    ov = 1'b0;
    un = 1'b0;
    case (opc)
      4'd1: begin s = sa + sb; c = a + b; ov = (s > 127); un = (s < -128); end
      4'd2: begin s = sa - sb; c = a - b; ov = (s > 127); un = (s < -128); end
      4'd3: c = a & b;
      4'd4: c = a | b;
      4'd5: c = ~a;
      default: return {W'($urandom), 5'($urandom)};
    endcase
    return {c, ov, un, (sa > sb), (sb > sa), (a == b)};
  endfunction

  always @(negedge clk) begin
    logic [W+4:0] r;
    r = alu_eval(bus.alu_instruction, bus.alu_operand_A, bus.alu_operand_B);
    bus.alu_operand_C = r[W+4:5];
    {bus.alu_ov, bus.alu_un, bus.alu_agt, bus.alu_bgt, bus.alu_eq} = r[4:0];
  end

  function automatic void ref_exec(input logic [15:0] w, output logic exp_err);
    logic [W+4:0] r;
    exp_err = 1'b0;
    case (w[15:12])
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        r = alu_eval(w[15:12], ref_regs[w[7:4]], ref_regs[w[3:0]]);
        ref_regs[w[11:8]] = r[W+4:5];
        ref_flags         = r[4:0];
      end
      default: exp_err = 1'b1;
    endcase
  endfunction

  task automatic host_write(input logic [3:0] addr, input logic [W-1:0] data);
    bus.host_we   = 1'b1;
    bus.host_addr = addr;
    bus.host_data = data;
    @(posedge clk); #1;
    bus.host_we = 1'b0;
    ref_regs[addr] = data;
  endtask

  // Issue one instruction from IDLE and check timing, err, flags and the whole regfile.
  task automatic run_instr(input string name, input logic [15:0] w);
    logic exp_err;
    int n;
    ref_exec(w, exp_err);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr_word  = w;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr_word  = 16'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL %s done_latency: got %0d edges want 2", name, n);
    end
    checks++;
    if (bus.err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, bus.err, exp_err);
    end
    checks++;
    if (bus.flags !== ref_flags) begin
      errors++;
      $display("FAIL %s flags: got %b want %b", name, bus.flags, ref_flags);
    end
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.alu_instruction !== 4'd0) begin
      errors++;
      $display("FAIL %s idle_after_done: got ready=%b opc=%h want ready=1 opc=0", name,
               bus.instr_ready, bus.alu_instruction);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: got done=%b err=%b want 0 0", name, bus.done, bus.err);
    end
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      checks++;
      if (bus.dbg_data !== ref_regs[i]) begin
        errors++;
        $display("FAIL %s reg[%0d]: got %h want %h", name, i, bus.dbg_data, ref_regs[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: got ready=%b done=%b err=%b want 1 0 0", bus.instr_ready,
               bus.done, bus.err);
    end
    checks++;
    if (bus.flags !== 5'b0 || bus.alu_instruction !== 4'd0 || bus.alu_operand_A !== 8'h00 ||
        bus.alu_operand_B !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got flags=%b opc=%h A=%h B=%h want all 0", bus.flags,
               bus.alu_instruction, bus.alu_operand_A, bus.alu_operand_B);
    end
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      checks++;
      if (bus.dbg_data !== 8'h00) begin
        errors++;
        $display("FAIL reset reg[%0d]: got %h want 00", i, bus.dbg_data);
      end
    end
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    ref_flags = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    host_write(4'd1, 8'h40);
    host_write(4'd2, 8'h40);
    run_instr("add", 16'h1312);
    bus.dbg_addr = 4'd3;
    #1;
    checks++;
    if (bus.dbg_data !== 8'h80 || bus.flags !== 5'b10001) begin
      errors++;
      $display("FAIL add_literal: got r3=%h flags=%b want 80 10001", bus.dbg_data, bus.flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    host_write(4'd1, 8'h05);
    host_write(4'd2, 8'h07);
    run_instr("sub_small", 16'h2412);
    bus.dbg_addr = 4'd4;
    #1;
    checks++;
    if (bus.dbg_data !== 8'hFE || bus.flags !== 5'b00010) begin
      errors++;
      $display("FAIL sub_small_literal: got r4=%h flags=%b want fe 00010", bus.dbg_data,
               bus.flags);
    end
    @(posedge clk); #1;
    host_write(4'd5, 8'h80);
    host_write(4'd6, 8'h01);
    run_instr("sub_underflow", 16'h2756);
    bus.dbg_addr = 4'd7;
    #1;
    checks++;
    if (bus.dbg_data !== 8'h7F || bus.flags !== 5'b01010) begin
      errors++;
      $display("FAIL sub_underflow_literal: got r7=%h flags=%b want 7f 01010", bus.dbg_data,
               bus.flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unknown_nop();
    run_instr("unknown", 16'hF312);
    bus.dbg_addr = 4'd3;
    #1;
    checks++;
    if (bus.dbg_data !== 8'h80 || bus.flags !== 5'b01010) begin
      errors++;
      $display("FAIL unknown_hold: got r3=%h flags=%b want 80 01010", bus.dbg_data, bus.flags);
    end
    @(posedge clk); #1;
    run_instr("nop", 16'h0312);
  endtask

  // Host writes while an instruction is accepted or in flight must be dropped.
  task automatic test_host_drop();
    logic exp_err;
    logic [W-1:0] old9;
    old9 = ref_regs[9];
    ref_exec(16'h1C12, exp_err);
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h1C12;
    bus.host_we     = 1'b1;
    bus.host_addr   = 4'd9;
    bus.host_data   = ~old9;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.host_we = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL host_drop done: got %b want 1", bus.done);
    end
    bus.dbg_addr = 4'd9;
    #1;
    checks++;
    if (bus.dbg_data !== old9) begin
      errors++;
      $display("FAIL host_drop reg9: got %h want %h", bus.dbg_data, old9);
    end
    bus.dbg_addr = 4'd12;
    #1;
    checks++;
    if (bus.dbg_data !== ref_regs[12]) begin
      errors++;
      $display("FAIL host_drop reg12: got %h want %h", bus.dbg_data, ref_regs[12]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [6];
    logic e1, e2;
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    host_write(4'd1, 8'h21);
    host_write(4'd2, 8'h13);
    ref_exec(16'h1A12, e1);
    ref_exec(16'h2BA1, e2);
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h1A12;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.instr_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL b2b ready[%0d]: got %b want %b", i, bus.instr_ready, exp_rdy[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.done !== 1'b1) begin
          errors++;
          $display("FAIL b2b first_done: got %b want 1", bus.done);
        end
      end
      @(posedge clk); #1;
      if (i == 0) bus.instr_word = 16'hF000;
      if (i == 1) bus.instr_word = 16'h2BA1;
      if (i == 3) bus.instr_valid = 1'b0;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.flags !== ref_flags) begin
      errors++;
      $display("FAIL b2b second_done: got done=%b err=%b flags=%b want 1 0 %b", bus.done,
               bus.err, bus.flags, ref_flags);
    end
    for (int r = 10; r < 12; r++) begin
      bus.dbg_addr = 4'(r);
      #1;
      checks++;
      if (bus.dbg_data !== ref_regs[r]) begin
        errors++;
        $display("FAIL b2b reg[%0d]: got %h want %h", r, bus.dbg_data, ref_regs[r]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] opc;
    int sel;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 3) begin
        host_write(4'($urandom), 8'($urandom));
      end
      sel = $urandom_range(0, 9);
      opc = (sel <= 5) ? 4'(sel) : 4'($urandom_range(6, 15));
      run_instr("random", {opc, 12'($urandom)});
    end
  endtask

  task automatic test_reset_in_issue();
    host_write(4'd1, 8'h33);
    host_write(4'd2, 8'h44);
    bus.instr_valid = 1'b1;
    bus.instr_word  = 16'h1812;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_issue in_flight: got ready=%b want 0", bus.instr_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || bus.flags !== 5'b0 ||
        bus.alu_instruction !== 4'd0) begin
      errors++;
      $display("FAIL rst_issue async: got done=%b ready=%b flags=%b opc=%h want 0 1 0 0",
               bus.done, bus.instr_ready, bus.flags, bus.alu_instruction);
    end
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      checks++;
      if (bus.dbg_data !== 8'h00) begin
        errors++;
        $display("FAIL rst_issue reg[%0d]: got %h want 00", i, bus.dbg_data);
      end
    end
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    ref_flags = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL rst_issue late_done[%0d]: got %b want 0", i, bus.done);
      end
    end
  endtask

  initial begin
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_word  = '0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_data   = '0;
    bus.dbg_addr    = '0;
    test_reset();
    test_add();
    test_sub();
    test_unknown_nop();
    test_host_drop();
    test_back_to_back();
    test_random();
    test_reset_in_issue();
    run_instr("after_reset", 16'h1312);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
